operand_loader: RTL
===================

Name: operand_loader

Overview:
- Upstream feeder of the element counter in the matrix-multiply datapath.
- Accepts a serial stream of matrix elements over a valid/ready handshake and stores them into two DIM×DIM operand register banks: A first, then B.
- Emits one clean registered register_ready pulse per stored element. The downstream rising-edge counter therefore wraps to zero and flags full after exactly 2·DIM·DIM elements.
- Raises load_done once both operands are resident and stable for the compute array.

Parameters:
- DATA_W, 8, width of one matrix element in bits.
- DIM, 4, matrix dimension. Total elements per load TOTAL = 2·DIM·DIM, 32 at default.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin or restart a load; sampled in IDLE and HOLD only.
- in_data  input  DATA_W  element value.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept an element this cycle.
- register_ready  output  1  registered one-cycle pulse per stored element.
- load_done  output  1  high in HOLD; A and B are complete and stable.
- busy  output  1  high in LOAD.
- a_flat  output  DATA_W·DIM·DIM  operand A; element (r,c) at bits [(r·DIM+c)·DATA_W +: DATA_W].
- b_flat  output  DATA_W·DIM·DIM  operand B, same layout.

Behaviour:
- Clocking and reset: one clock domain. rst_n is synchronous and active-low.
- Reset values: state=IDLE, idx=0, in_ready=0, register_ready=0, load_done=0, busy=0, a_flat=0, b_flat=0.
- State machine:
  - IDLE: start=1 → LOAD, idx←0.
  - LOAD: busy=1. Acceptance = in_valid & in_ready. On acceptance of the element at index TOTAL-1 → HOLD.
  - HOLD: load_done=1, in_ready=0, both banks frozen. start=1 → LOAD, idx←0. Banks are not cleared and are overwritten as the new stream arrives.
- in_ready (registered):
  - Asserted in LOAD except in the cycle immediately after an acceptance.
  - Maximum throughput is one element per 2 cycles. This guarantees register_ready returns low between pulses, so the downstream edge counter never misses a count.
- Storage on acceptance:
  - idx < DIM·DIM: write A element idx.
  - Otherwise: write B element idx-DIM·DIM.
  - idx increments by 1; idx width is clog2(TOTAL)+1.
  - No wrap inside a load: the final acceptance moves the FSM to HOLD.
- register_ready: high exactly in the cycle after each acceptance, low otherwise. Exactly TOTAL pulses per complete load.
- load_done: rises the cycle after the final acceptance, coinciding with the last register_ready pulse. Stays high until the next start is taken or rst_n is asserted.
- Inputs ignored:
  - in_valid is ignored when in_ready=0; no storage, no pulse.
  - in_data is ignored without in_valid.
- start during LOAD is ignored; the load continues uninterrupted.
- start and the final acceptance in the same cycle: start is ignored and the FSM goes to HOLD.
- Reset mid-load: all outputs return to reset values on the next edge, and the partial load is discarded. The downstream counter must be reset alongside.

Optional Feature:
- Macro OPERAND_LOADER_TRANSPOSE_B_EN.
- Defined: B is stored transposed. The j-th B element of the stream (r=j/DIM, c=j%DIM) is written to position c·DIM+r of b_flat. This presents B columns contiguously to the compute array. A is unaffected.
- Undefined: B uses the same row-major mapping as A.
- Handshake, pulse timing and counts are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 and in_valid=1 → all outputs 0, state IDLE, no register_ready pulse.
- Full load: start, then stream values 1..32 with in_valid held high.
  - Accepted on alternate cycles.
  - 32 register_ready pulses, each 1 cycle wide with a low cycle between.
  - load_done rises with the 32nd pulse.
  - a_flat element (0,0)=1 and (3,3)=16; b_flat element (0,0)=17 and (3,3)=32.
  - With the transpose macro: b_flat element (0,1)=21 and (1,0)=18.
- Stalls: toggle in_valid pseudo-randomly across a 32-element load → storage occurs only on acceptance, exactly 32 pulses, final banks match the sent sequence.
- Ignored start and hold-off: start pulsed mid-load at idx=10 → no restart, idx continues. in_valid while in HOLD → in_ready=0, banks unchanged, no pulse.
- Reload: start in HOLD, then stream 100..131 → load_done drops the next cycle; banks are overwritten in order; load_done returns after 32 pulses; a_flat element (0,0)=100.
- Reset mid-load: assert rst_n=0 after 7 acceptances → banks 0, idx 0, IDLE. A subsequent full load completes with exactly 32 pulses.

Source files
------------

// File: rtl/operand_loader.sv
// Streams 2*DIM*DIM elements over valid/ready into operand banks A then B, one register_ready pulse per element.
// Optional build macro OPERAND_LOADER_TRANSPOSE_B_EN stores B transposed (column-major) for the compute array.
module operand_loader #(
  parameter int DATA_W = 8,
  parameter int DIM    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       register_ready,
  output logic                       load_done,
  output logic                       busy,
  output logic [DATA_W*DIM*DIM-1:0]  a_flat,
  output logic [DATA_W*DIM*DIM-1:0]  b_flat
);

  localparam int NE    = DIM * DIM;
  localparam int TOTAL = 2 * NE;
  localparam int IDX_W = $clog2(TOTAL) + 1;
  localparam int POS_W = $clog2(NE) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                     state_r;
  logic [IDX_W-1:0]           idx_r;
  logic                       in_ready_r;
  logic                       register_ready_r;
  logic                       load_done_r;
  logic                       busy_r;
  logic [DATA_W*NE-1:0]       a_flat_r;
  logic [DATA_W*NE-1:0]       b_flat_r;

  logic                       accept_s;
  logic                       last_s;
  logic                       in_a_s;
  logic [IDX_W-1:0]           b_idx_s;
  logic [POS_W-1:0]           a_pos_s;
  logic [POS_W-1:0]           b_pos_s;

  // Decode acceptance, final element and bank target position for the current index
  always_comb begin
    accept_s = (state_r == LOAD) && in_valid && in_ready_r;
    last_s   = (idx_r == IDX_W'(TOTAL - 1));
    b_idx_s  = idx_r - IDX_W'(NE);
    a_pos_s  = POS_W'(idx_r);
`ifdef OPERAND_LOADER_TRANSPOSE_B_EN
    b_pos_s  = POS_W'((b_idx_s % IDX_W'(DIM)) * IDX_W'(DIM) + (b_idx_s / IDX_W'(DIM)));
`else
    b_pos_s  = POS_W'(b_idx_s);
`endif
    if (idx_r < IDX_W'(NE)) begin
      in_a_s = 1'b1;
    end else begin
      in_a_s = 1'b0;
    end
  end

  // Load FSM with operand banks and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      idx_r            <= '0;
      in_ready_r       <= 1'b0;
      register_ready_r <= 1'b0;
      load_done_r      <= 1'b0;
      busy_r           <= 1'b0;
      a_flat_r         <= '0;
      b_flat_r         <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          register_ready_r <= 1'b0;
          load_done_r      <= 1'b0;
          if (start) begin
            state_r    <= LOAD;
            idx_r      <= '0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        LOAD: begin
          if (accept_s) begin
            if (in_a_s) begin
              a_flat_r[a_pos_s*DATA_W +: DATA_W] <= in_data;
            end else begin
              b_flat_r[b_pos_s*DATA_W +: DATA_W] <= in_data;
            end
            idx_r            <= idx_r + IDX_W'(1);
            register_ready_r <= 1'b1;
            // Dropping ready for one cycle guarantees a low gap between pulses
            in_ready_r       <= 1'b0;
            if (last_s) begin
              state_r     <= HOLD;
              busy_r      <= 1'b0;
              load_done_r <= 1'b1;
            end else begin
              state_r     <= LOAD;
              busy_r      <= 1'b1;
              load_done_r <= 1'b0;
            end
          end else begin
            register_ready_r <= 1'b0;
            in_ready_r       <= 1'b1;
            busy_r           <= 1'b1;
            load_done_r      <= 1'b0;
          end
        end
        HOLD: begin
          register_ready_r <= 1'b0;
          if (start) begin
            state_r     <= LOAD;
            idx_r       <= '0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b1;
            load_done_r <= 1'b0;
          end else begin
            state_r     <= HOLD;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            load_done_r <= 1'b1;
          end
        end
        default: begin
          state_r          <= IDLE;
          idx_r            <= '0;
          in_ready_r       <= 1'b0;
          register_ready_r <= 1'b0;
          load_done_r      <= 1'b0;
          busy_r           <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_r;
  assign register_ready = register_ready_r;
  assign load_done      = load_done_r;
  assign busy           = busy_r;
  assign a_flat         = a_flat_r;
  assign b_flat         = b_flat_r;

endmodule
